imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/cpu_pkg.sv | 15 +
 rtl/imem_arbiter_if.sv | 30 +++
 rtl/byte_select.sv | 14 +
 rtl/imem_arbiter.sv | 100 ++++++++++
 tb/tb_imem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter FSM encoding and the default fetch bubble word.
package cpu_pkg;

    // Print-arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Instruction handed to fetch while the arbiter owns instruction memory
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/imem_arbiter_if.sv
// Signal bundle between the CPU side (fetch, print requester, memory, console)
// and the instruction-memory print arbiter.
interface imem_arbiter_if;
    logic [31:0] fetch_addr;
    logic        print_req;
    logic [31:0] print_base;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] fetch_instr;
    logic        stall_fetch;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        print_done;
    logic        busy;

    // CPU / environment side
    modport master (
        output fetch_addr, print_req, print_base, mem_rdata, char_ready,
        input  mem_addr, fetch_instr, stall_fetch, char_valid, char_data,
               print_done, busy
    );

    // Arbiter side
    modport slave (
        input  fetch_addr, print_req, print_base, mem_rdata, char_ready,
        output mem_addr, fetch_instr, stall_fetch, char_valid, char_data,
               print_done, busy
    );
endinterface : imem_arbiter_if

// File: rtl/byte_select.sv
// Little-endian byte-lane extractor: lane 0 is bits 7:0 of the word.
module byte_select (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    output logic [7:0]  o_byte
);
    logic [7:0] w_lane [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = i_word[gi*8 +: 8];
    end

    assign o_byte = w_lane[i_offset];
endmodule : byte_select

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: steals the fetch port to stream a NUL-terminated
// string out of instruction memory, one byte per READ/EMIT pair, to a console sink.
module imem_arbiter
    import cpu_pkg::*;
#(
    parameter int          MAX_LEN  = 256,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_arbiter_if.slave bus
);
    // Wide enough to hold MAX_LEN itself, the terminating count value
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [31:0]      r_ptr;
    logic [31:0]      w_ptr_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_inc;
    logic [7:0]       r_char_data;
    logic [7:0]       w_char_next;
    logic [7:0]       w_byte;

    byte_select u_byte_select (
        .i_word   (bus.mem_rdata),
        .i_offset (r_ptr[1:0]),
        .o_byte   (w_byte)
    );

    assign w_count_inc = r_count + CNT_W'(1);

    // Memory port steering: the string word address only while reading a character
    assign bus.mem_addr    = (r_state == ST_READ) ? {r_ptr[31:2], 2'b00} : bus.fetch_addr;
    assign bus.fetch_instr = (r_state == ST_IDLE) ? bus.mem_rdata : NOP_WORD;
    assign bus.char_data   = r_char_data;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_count     <= '0;
            r_char_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_count     <= w_count_next;
            r_char_data <= w_char_next;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_count_next     = r_count;
        w_char_next      = r_char_data;
        bus.stall_fetch  = 1'b0;
        bus.char_valid   = 1'b0;
        bus.print_done   = 1'b0;
        bus.busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.print_req) begin
                    w_ptr_next   = bus.print_base;
                    w_count_next = '0;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                bus.stall_fetch = 1'b1;
                w_char_next     = w_byte;
                // A NUL byte ends the string without being emitted
                w_state_next    = (w_byte == 8'h00) ? ST_DONE : ST_EMIT;
            end
            ST_EMIT: begin
                bus.stall_fetch = 1'b1;
                bus.char_valid  = 1'b1;
                if (bus.char_ready) begin
                    w_ptr_next   = r_ptr + 32'd1;
                    w_count_next = w_count_inc;
                    w_state_next = (w_count_inc == CNT_W'(MAX_LEN)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                // Requester still holds print_req here; it is deliberately ignored
                bus.print_done = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end
endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_imem_arbiter;
    localparam logic [31:0] FETCH_PC = 32'h0000_0020;
    localparam logic [31:0] FETCH_IW = 32'hDEAD_BEEF;
    localparam logic [31:0] STR_BASE = 32'h1000_0000;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    imem_arbiter_if bus ();
    imem_arbiter_if bus4 ();

    imem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    imem_arbiter #(.MAX_LEN(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    // Small instruction memory model indexed by word address bits 5:2
    logic [31:0] mem_w [16];
    always_comb bus.mem_rdata  = mem_w[bus.mem_addr[5:2]];
    always_comb bus4.mem_rdata = mem_w[bus4.mem_addr[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        req;
        logic        rdy;
        logic        exp_busy;
        logic        exp_stall;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_done;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic req, input logic busy, input logic stall,
                                input logic valid, input logic [7:0] data, input logic done,
                                input logic chk_addr, input logic [31:0] addr,
                                input logic [31:0] instr);
        vec_t v;
        v.req = req; v.rdy = 1'b1; v.exp_busy = busy; v.exp_stall = stall;
        v.exp_valid = valid; v.exp_data = data; v.exp_done = done;
        v.chk_addr = chk_addr; v.exp_addr = addr; v.exp_instr = instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0]  chars_q [$];
    logic [31:0] raddr_q [$];

    // Runs one print transaction with char_ready=1; records emitted characters and READ
    // addresses; done_at is the cycle index of print_done counted from acceptance (0).
    task automatic do_print(input bit sel, input logic [31:0] base, output int done_at);
        logic st, v, dn, rdy, bsy;
        logic [7:0] d;
        logic [31:0] a, fi;
        chars_q.delete();
        raddr_q.delete();
        done_at = -1;
        if (sel) begin bus4.print_req = 1'b1; bus4.print_base = base; end
        else     begin bus.print_req  = 1'b1; bus.print_base  = base; end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sel) begin
                st = bus4.stall_fetch; v = bus4.char_valid; dn = bus4.print_done;
                d = bus4.char_data; a = bus4.mem_addr; rdy = bus4.char_ready;
            end else begin
                st = bus.stall_fetch; v = bus.char_valid; dn = bus.print_done;
                d = bus.char_data; a = bus.mem_addr; rdy = bus.char_ready;
            end
            if (st && !v) raddr_q.push_back(a);
            if (v && rdy) chars_q.push_back(d);
            if (dn) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("print_done_seen", 32'(done_at >= 0), 32'd1);
        @(posedge clk); #1;
        bus.print_req  = 1'b0;
        bus4.print_req = 1'b0;
        @(negedge clk);
        if (sel) begin bsy = bus4.busy; dn = bus4.print_done; fi = bus4.fetch_instr; end
        else     begin bsy = bus.busy;  dn = bus.print_done;  fi = bus.fetch_instr;  end
        check("idle_busy_after_done", 32'(bsy), 32'd0);
        check("done_single_pulse", 32'(dn), 32'd0);
        check("idle_fetch_instr", fi, FETCH_IW);
        $display("print base=%h chars=%0d done_at=%0d", base, chars_q.size(), done_at);
        @(posedge clk); #1;
    endtask

    task automatic cmp_queues(input string tag, input logic [7:0] exp_c [$],
                              input logic [31:0] exp_a [$]);
        check({tag, "_nchars"}, 32'(chars_q.size()), 32'(exp_c.size()));
        for (int i = 0; i < exp_c.size() && i < chars_q.size(); i++)
            check($sformatf("%s_char%0d", tag, i), 32'(chars_q[i]), 32'(exp_c[i]));
        check({tag, "_nreads"}, 32'(raddr_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < raddr_q.size(); i++)
            check($sformatf("%s_raddr%0d", tag, i), raddr_q[i], exp_a[i]);
    endtask

    initial begin
        int done_at;
        logic [7:0]  ec [$];
        logic [31:0] ea [$];

        for (int i = 0; i < 16; i++) mem_w[i] = 32'h0;
        mem_w[8] = FETCH_IW;
        rst_n = 1'b0;
        bus.fetch_addr = FETCH_PC;  bus4.fetch_addr = FETCH_PC;
        bus.print_req  = 1'b0;      bus4.print_req  = 1'b0;
        bus.print_base = STR_BASE;  bus4.print_base = STR_BASE;
        bus.char_ready = 1'b1;      bus4.char_ready = 1'b1;

        // ---- Reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall_fetch), 32'd0);
        check("rst_valid", 32'(bus.char_valid), 32'd0);
        check("rst_done", 32'(bus.print_done), 32'd0);
        check("rst_char_data", 32'(bus.char_data), 32'd0);
        check("rst_mem_addr", bus.mem_addr, FETCH_PC);
        check("rst_fetch_instr", bus.fetch_instr, FETCH_IW);
        check("rst_busy4", 32'(bus4.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- "Hi" twice back-to-back, per-cycle table ----
        mem_w[0] = 32'h0000_6948;
        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 1, FETCH_PC, FETCH_IW);
        tbl[1]  = mk(1, 1, 1, 0, 8'h00, 0, 1, STR_BASE, 32'h0);
        tbl[2]  = mk(1, 1, 1, 1, 8'h48, 0, 1, FETCH_PC, 32'h0);
        tbl[3]  = mk(1, 1, 1, 0, 8'h00, 0, 1, STR_BASE, 32'h0);
        tbl[4]  = mk(1, 1, 1, 1, 8'h69, 0, 1, FETCH_PC, 32'h0);
        tbl[5]  = mk(1, 1, 1, 0, 8'h00, 0, 1, STR_BASE, 32'h0);
        tbl[6]  = mk(1, 1, 0, 0, 8'h00, 1, 0, 32'h0,    32'h0);
        tbl[7]  = mk(1, 0, 0, 0, 8'h00, 0, 1, FETCH_PC, FETCH_IW);
        for (int i = 8; i < 14; i++) tbl[i] = tbl[i-7];
        tbl[14] = mk(0, 0, 0, 0, 8'h00, 0, 1, FETCH_PC, FETCH_IW);
        for (int i = 0; i < 15; i++) begin
            bus.print_req  = tbl[i].req;
            bus.char_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_stall", i), 32'(bus.stall_fetch), 32'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_valid", i), 32'(bus.char_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_done", i), 32'(bus.print_done), 32'(tbl[i].exp_done));
            check($sformatf("tbl%0d_instr", i), bus.fetch_instr, tbl[i].exp_instr);
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_data", i), 32'(bus.char_data), 32'(tbl[i].exp_data));
            if (tbl[i].chk_addr)
                check($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].exp_addr);
            $display("vector %0d req=%b valid=%b data=%h done=%b", i, tbl[i].req,
                     bus.char_valid, bus.char_data, bus.print_done);
            @(posedge clk); #1;
        end

        // ---- Backpressure: char_ready low for 4 cycles in EMIT ----
        bus.char_ready = 1'b0;
        bus.print_req  = 1'b1;
        bus.print_base = STR_BASE;
        @(posedge clk); #1;                      // accepted -> READ
        @(posedge clk); #1;                      // -> EMIT
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), 32'(bus.char_valid), 32'd1);
            check($sformatf("bp%0d_data", k), 32'(bus.char_data), 32'h48);
            check($sformatf("bp%0d_stall", k), 32'(bus.stall_fetch), 32'd1);
            @(posedge clk); #1;
        end
        bus.char_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.char_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_read_addr", bus.mem_addr, STR_BASE);
        check("bp_next_read_valid", 32'(bus.char_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_second_char", 32'(bus.char_data), 32'h69);
        check("bp_second_valid", 32'(bus.char_valid), 32'd1);
        for (int k = 0; k < 10 && !bus.print_done; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("bp_done", 32'(bus.print_done), 32'd1);
        $display("backpressure transaction complete");
        @(posedge clk); #1;
        bus.print_req = 1'b0;
        @(posedge clk); #1;

        // ---- Unaligned base spanning a word boundary ----
        mem_w[0] = 32'h4100_0000;
        mem_w[1] = 32'h0000_0042;
        do_print(1'b0, 32'h1000_0003, done_at);
        ec = '{8'h41, 8'h42};
        ea = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0004};
        cmp_queues("unaligned", ec, ea);
        check("unaligned_done_at", 32'(done_at), 32'd6);

        // ---- Empty string ----
        mem_w[0] = 32'h4142_4300;
        do_print(1'b0, STR_BASE, done_at);
        ec = {};
        ea = '{STR_BASE};
        cmp_queues("empty", ec, ea);
        check("empty_done_at", 32'(done_at), 32'd2);

        // ---- MAX_LEN=4, no terminator, pointer wraps ----
        mem_w[15] = 32'h5857_0000;
        mem_w[0]  = 32'h3130_5A59;
        do_print(1'b1, 32'hFFFF_FFFE, done_at);
        ec = '{8'h57, 8'h58, 8'h59, 8'h5A};
        ea = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        cmp_queues("maxlen", ec, ea);
        check("maxlen_done_at", 32'(done_at), 32'd9);

        // ---- Reset mid-EMIT aborts the transaction ----
        mem_w[0] = 32'h0000_6948;
        bus.char_ready = 1'b0;
        bus.print_req  = 1'b1;
        bus.print_base = STR_BASE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_emit_valid", 32'(bus.char_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.print_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("rstmid%0d_valid", k), 32'(bus.char_valid), 32'd0);
            check($sformatf("rstmid%0d_done", k), 32'(bus.print_done), 32'd0);
            check($sformatf("rstmid%0d_stall", k), 32'(bus.stall_fetch), 32'd0);
            check($sformatf("rstmid%0d_busy", k), 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.char_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d_done", k), 32'(bus.print_done), 32'd0);
            check($sformatf("post_rst%0d_valid", k), 32'(bus.char_valid), 32'd0);
            @(posedge clk); #1;
        end
        $display("reset abort sequence complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_imem_arbiter
